// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with forwarding, load-use bubbles and ALU operand select (optional EX_STAGE_PERF_EN)
module ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_asel_pc,
    input  logic                     id_alusrc,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     id_memwrite,
    input  logic                     flush,
    input  logic                     ex_ready,
    input  logic [REG_ADDR-1:0]      mem_rd,
    input  logic [REG_ADDR-1:0]      wb_rd,
    input  logic                     mem_regwrite,
    input  logic                     wb_regwrite,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic                     ex_memwrite,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     load_use_stall
`ifdef EX_STAGE_PERF_EN
    ,
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_bubbles
`endif
);

    logic                     valid_q,     valid_d;
    logic [DATA_WIDTH-1:0]    rs1_data_q,  rs1_data_d;
    logic [DATA_WIDTH-1:0]    rs2_data_q,  rs2_data_d;
    logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
    logic [DATA_WIDTH-1:0]    pc_q,        pc_d;
    logic [REG_ADDR-1:0]      rs1_q,       rs1_d;
    logic [REG_ADDR-1:0]      rs2_q,       rs2_d;
    logic [REG_ADDR-1:0]      rd_q,        rd_d;
    logic [OPCODE_LENGTH-1:0] alu_op_q,    alu_op_d;
    logic                     asel_pc_q,   asel_pc_d;
    logic                     alusrc_q,    alusrc_d;
    logic                     regwrite_q,  regwrite_d;
    logic                     memread_q,   memread_d;
    logic                     memwrite_q,  memwrite_d;

    logic                     accept;
    logic                     stall;
    logic [DATA_WIDTH-1:0]    fwd_rs1;
    logic [DATA_WIDTH-1:0]    fwd_rs2;

    // Load-use hazard and upstream handshake; a load in EX cannot feed a dependent in ID yet
    always_comb begin
        stall = valid_q && memread_q && (rd_q != '0) && id_valid &&
                ((id_rs1 == rd_q) || (id_rs2 == rd_q));
        id_ready = (!valid_q || ex_ready) && !stall;
        accept   = id_valid && id_ready;
    end

    // Next-state selection: flush beats capture beats drain; holding refreshes stale operands from WB
    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        asel_pc_d  = asel_pc_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            pc_d       = id_pc;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            alu_op_d   = id_alu_op;
            asel_pc_d  = id_asel_pc;
            alusrc_d   = id_alusrc;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // The WB value would otherwise retire before this instruction leaves EX
            if (wb_regwrite && (wb_rd == rs1_q) && (rs1_q != '0)) rs1_data_d = wb_result;
            if (wb_regwrite && (wb_rd == rs2_q) && (rs2_q != '0)) rs2_data_d = wb_result;
        end
    end

    // Pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_op_q   <= '0;
            asel_pc_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            alu_op_q   <= alu_op_d;
            asel_pc_q  <= asel_pc_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    // Forwarding per source: MEM is younger than WB so it wins; x0 is hardwired and never forwarded
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (wb_regwrite && (wb_rd == rs1_q) && (rs1_q != '0))   fwd_rs1 = wb_result;
        if (mem_regwrite && (mem_rd == rs1_q) && (rs1_q != '0)) fwd_rs1 = mem_result;
        fwd_rs2 = rs2_data_q;
        if (wb_regwrite && (wb_rd == rs2_q) && (rs2_q != '0))   fwd_rs2 = wb_result;
        if (mem_regwrite && (mem_rd == rs2_q) && (rs2_q != '0)) fwd_rs2 = mem_result;
    end

    // Operand selection and control gating; an empty slot presents the all-ones op so the ALU yields 0
    always_comb begin
        SrcA           = asel_pc_q ? pc_q : fwd_rs1;
        SrcB           = alusrc_q ? imm_q : fwd_rs2;
        ex_store_data  = fwd_rs2;
        Operation      = valid_q ? alu_op_q : {OPCODE_LENGTH{1'b1}};
        ex_valid       = valid_q;
        ex_rd          = rd_q;
        ex_regwrite    = valid_q && regwrite_q;
        ex_memread     = valid_q && memread_q;
        ex_memwrite    = valid_q && memwrite_q;
        load_use_stall = stall;
    end

`ifdef EX_STAGE_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_bubble_q;

    // Wrapping event counters: refused offers, and load-use bubbles actually entering EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (id_valid && !id_ready)          perf_stall_q  <= perf_stall_q + 32'd1;
            if (stall && ex_ready && !flush)    perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_bubbles      = perf_bubble_q;
`endif

endmodule
